sap_sequencer: RTL and testbench
================================

Name: sap_sequencer

Overview:
- Controller/sequencer for the SAP-1 computer: a six-state T-state ring counter plus opcode decode that generates the per-T-state control word driving PC, MAR, RAM, IR, accumulator, B register, ALU and output register.
- Replaces the manual sel/OE/WE selection so programs execute from RAM.
- Supports free-run and debounced single-step operation.
- Includes a sticky halt and a retired-instruction counter.

Parameters:
- COUNT_W, 8, width of instr_count.
- SYNC_STAGES, 2, synchroniser depth on step_in (minimum 2).

Ports:
- CLK  input  1  system clock, all state on posedge.
- RESET  input  1  asynchronous, active-high reset.
- run  input  1  1 = free-run: advance one T-state per clock.
- step_in  input  1  debounced step button level; each rising edge advances one T-state when run=0.
- opcode  input  4  IR upper nibble; decoded only in T4–T6.
- t_state  output  6  one-hot T-state, bit0 = T1.
- pc_oe  output  1  PC drives bus.
- pc_inc  output  1  PC increment strobe.
- mar_we  output  1  MAR loads from bus.
- ram_oe  output  1  RAM drives bus.
- ir_we  output  1  IR loads from bus.
- ir_oe  output  1  IR operand nibble drives bus.
- acc_we  output  1  accumulator loads from bus.
- acc_oe  output  1  accumulator drives bus.
- breg_we  output  1  B register loads from bus.
- alu_sub  output  1  ALU subtract select.
- alu_oe  output  1  ALU drives bus.
- out_we  output  1  output register loads from bus.
- halted  output  1  sticky halt flag.
- instr_count  output  COUNT_W  instructions retired.

Behaviour:
- Reset (asynchronous, any time, including mid-instruction):
  - t_state=6'b000001, halted=0, instr_count=0, synchroniser and edge flops=0.
  - All strobes are low during reset.
- Advance term: adv = ~halted & (run | step_pulse).
  - step_pulse is one clock wide, taken from the rising edge of the synchronised step_in.
  - Latency with SYNC_STAGES=2: step_in rises before edge k; the T-state changes at edge k+2.
  - step_pulse is ignored while run=1 or while halted.
- Ring counter: on each adv the state advances T1→T2→…→T6→T1. Without adv the state holds.
- Signal classes:
  - Bus-drive signals (pc_oe, ram_oe, ir_oe, acc_oe, alu_oe, alu_sub) are combinational from t_state/opcode and held for the whole T-state.
  - Write/increment strobes (pc_inc, mar_we, ir_we, acc_we, breg_we, out_we) are the same decode ANDed with adv, so exactly one register write happens per T-state even while stepping.
- Microcode, common fetch:
  - T1: pc_oe, mar_we.
  - T2: pc_inc.
  - T3: ram_oe, ir_we.
- Microcode, execute:
  - LDA (0000): T4 ir_oe, mar_we; T5 ram_oe, acc_we; T6 none.
  - ADD (0001): T4 ir_oe, mar_we; T5 ram_oe, breg_we; T6 alu_oe, acc_we.
  - SUB (0010): as ADD, and alu_sub is also asserted in T6.
  - OUT (1110): T4 acc_oe, out_we; T5 and T6 none.
  - HLT (1111): T4 no strobes. On adv in T4: halted←1 and t_state stays T4. Halt clears only on RESET.
  - Any other opcode: NOP, T4–T6 no signals.
- Bus exclusivity: at most one *_oe is asserted in any state; the microcode table guarantees this.
- instr_count increments on the adv taken in T6 (T6→T1 transition) and wraps from max to 0. HLT does not increment it.
- Run deasserted mid-instruction: the state freezes and the strobes drop the same cycle. Resuming continues from the frozen T-state.
- opcode changing during T1–T3 has no effect on outputs.

Decomposition:
- Package sap_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - T-state one-hot localparams T1..T6;
  - a packed control-word struct ctrl_t (the 12 control bits).
- Sub-module step_sync_edge (SYNC_STAGES-deep synchroniser plus rising-edge detect) produces step_pulse.
- Microcode decode is a function returning ctrl_t; the gating by adv happens in the top.

Test Plan:
- Reset then run=1, opcode=0000 (LDA): t_state cycles 01,02,04,08,10,20,01. mar_we is high in T1 and T4, acc_we in T5. instr_count=1 after 6 clocks.
- run=1, opcode=0010 (SUB): in T6 alu_sub=1, alu_oe=1, acc_we=1 in the same cycle; breg_we=1 in T5. No two *_oe high in any cycle.
- run=0, step_in held high for 100 clocks, then low: t_state advances exactly once, 2 clocks after the first sampling edge. pc_oe stays high throughout T1, and mar_we pulses once.
- run=1, opcode=1111 (HLT): halted=1 after the T4 adv; t_state stays 08 indefinitely; step pulses and run toggles cause no change; instr_count does not increment.
- 256 NOP instructions with COUNT_W=8, run=1: instr_count wraps 255→0 on the 256th T6→T1 transition.
- RESET asserted asynchronously mid-T5 of ADD: t_state=01, all strobes=0 and halted=0 immediately, without waiting for a clock edge. Execution restarts at T1 after release.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP-1 sequencer definitions: opcodes, one-hot T-states, control word
// and the microcode decode table.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct packed {
        logic pc_oe;
        logic pc_inc;
        logic mar_we;
        logic ram_oe;
        logic ir_we;
        logic ir_oe;
        logic acc_we;
        logic acc_oe;
        logic breg_we;
        logic alu_sub;
        logic alu_oe;
        logic out_we;
    } ctrl_t;

    // Ungated microcode; the opcode only matters once the fetch is complete.
    function automatic ctrl_t decode(input logic [5:0] t, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (t)
            T1: begin
                c.pc_oe  = 1'b1;
                c.mar_we = 1'b1;
            end
            T2: c.pc_inc = 1'b1;
            T3: begin
                c.ram_oe = 1'b1;
                c.ir_we  = 1'b1;
            end
            T4: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        c.ir_oe  = 1'b1;
                        c.mar_we = 1'b1;
                    end
                    OP_OUT: begin
                        c.acc_oe = 1'b1;
                        c.out_we = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (op)
                    OP_LDA: begin
                        c.ram_oe = 1'b1;
                        c.acc_we = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        c.ram_oe  = 1'b1;
                        c.breg_we = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    c.alu_oe = 1'b1;
                    c.acc_we = 1'b1;
                    c.alu_sub = (op == OP_SUB);
                end
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/step_sync_edge.sv
// Synchronises the step button level into the clock domain and emits a
// single-cycle pulse on each rising edge of the synchronised level.
module step_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic step_in,
    output logic step_pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], step_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign step_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/sap_sequencer.sv
// SAP-1 controller: one-hot T-state ring, microcode decode, sticky halt and
// retired-instruction counter, advancing on free-run or single-step.
module sap_sequencer
    import sap_pkg::*;
#(
    parameter int COUNT_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               run,
    input  logic               step_in,
    input  logic [3:0]         opcode,
    output logic [5:0]         t_state,
    output logic               pc_oe,
    output logic               pc_inc,
    output logic               mar_we,
    output logic               ram_oe,
    output logic               ir_we,
    output logic               ir_oe,
    output logic               acc_we,
    output logic               acc_oe,
    output logic               breg_we,
    output logic               alu_sub,
    output logic               alu_oe,
    output logic               out_we,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    logic [5:0]         t_state_q, t_state_d;
    logic               halted_q, halted_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               step_pulse;
    logic               adv;
    logic               wr_en;
    ctrl_t              dec;

    step_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step (
        .clk        (CLK),
        .rst        (RESET),
        .step_in    (step_in),
        .step_pulse (step_pulse)
    );

    always_comb begin
        dec       = decode(t_state_q, opcode);
        adv       = ~halted_q & (run | step_pulse);
        t_state_d = t_state_q;
        halted_d  = halted_q;
        count_d   = count_q;
        if (adv) begin
            // HLT parks in T4 rather than completing the instruction.
            if (t_state_q == T4 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                t_state_d = {t_state_q[4:0], t_state_q[5]};
                if (t_state_q == T6) begin
                    count_d = count_q + COUNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            t_state_q <= T1;
            halted_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            t_state_q <= t_state_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
        end
    end

    // Reset forces every control line low, independent of the clock.
    assign wr_en = adv & ~RESET;

    assign pc_oe   = dec.pc_oe   & ~RESET;
    assign ram_oe  = dec.ram_oe  & ~RESET;
    assign ir_oe   = dec.ir_oe   & ~RESET;
    assign acc_oe  = dec.acc_oe  & ~RESET;
    assign alu_oe  = dec.alu_oe  & ~RESET;
    assign alu_sub = dec.alu_sub & ~RESET;

    assign pc_inc  = dec.pc_inc  & wr_en;
    assign mar_we  = dec.mar_we  & wr_en;
    assign ir_we   = dec.ir_we   & wr_en;
    assign acc_we  = dec.acc_we  & wr_en;
    assign breg_we = dec.breg_we & wr_en;
    assign out_we  = dec.out_we  & wr_en;

    assign t_state     = t_state_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Self-checking bench for sap_sequencer: directed phases plus random run/step
// activity, compared each cycle against an instruction-level reference model.
module tb_sap_sequencer;

    logic       CLK;
    logic       RESET;
    logic       run;
    logic       step_in;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       pc_oe, pc_inc, mar_we, ram_oe, ir_we, ir_oe;
    logic       acc_we, acc_oe, breg_we, alu_sub, alu_oe, out_we;
    logic       halted;
    logic [7:0] instr_count;

    sap_sequencer #(.COUNT_W(8), .SYNC_STAGES(2)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .run         (run),
        .step_in     (step_in),
        .opcode      (opcode),
        .t_state     (t_state),
        .pc_oe       (pc_oe),
        .pc_inc      (pc_inc),
        .mar_we      (mar_we),
        .ram_oe      (ram_oe),
        .ir_we       (ir_we),
        .ir_oe       (ir_oe),
        .acc_we      (acc_we),
        .acc_oe      (acc_oe),
        .breg_we     (breg_we),
        .alu_sub     (alu_sub),
        .alu_oe      (alu_oe),
        .out_we      (out_we),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Word order: pc_oe pc_inc mar_we ram_oe ir_we ir_oe acc_we acc_oe breg_we alu_sub alu_oe out_we
    localparam int PC_OE = 11, PC_INC = 10, MAR_WE = 9, RAM_OE = 8, IR_WE = 7, IR_OE = 6;
    localparam int ACC_WE = 5, ACC_OE = 4, BREG_WE = 3, ALU_SUB = 2, ALU_OE = 1, OUT_WE = 0;
    localparam logic [11:0] BUS_MASK = 12'b1001_0101_0110;
    localparam logic [11:0] WR_MASK  = ~BUS_MASK;

    int passed = 0;
    int total  = 0;

    // Reference model: instruction step 0..5, halt flag, retired count, and
    // the last three sampled step_in values (newest first).
    int m_step;
    bit m_halted;
    int m_count;
    bit h0, h1, h2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] ref_word(input int step, input logic [3:0] op);
        logic [11:0] w;
        bit mem_op;
        w = '0;
        mem_op = (op == 4'h0 || op == 4'h1 || op == 4'h2);
        case (step)
            0: begin w[PC_OE] = 1; w[MAR_WE] = 1; end
            1: w[PC_INC] = 1;
            2: begin w[RAM_OE] = 1; w[IR_WE] = 1; end
            3: begin
                if (mem_op) begin w[IR_OE] = 1; w[MAR_WE] = 1; end
                if (op == 4'hE) begin w[ACC_OE] = 1; w[OUT_WE] = 1; end
            end
            4: begin
                if (op == 4'h0) begin w[RAM_OE] = 1; w[ACC_WE] = 1; end
                if (op == 4'h1 || op == 4'h2) begin w[RAM_OE] = 1; w[BREG_WE] = 1; end
            end
            5: begin
                if (op == 4'h1 || op == 4'h2) begin w[ALU_OE] = 1; w[ACC_WE] = 1; end
                if (op == 4'h2) w[ALU_SUB] = 1;
            end
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [11:0] obs_word();
        return {pc_oe, pc_inc, mar_we, ram_oe, ir_we, ir_oe,
                acc_we, acc_oe, breg_we, alu_sub, alu_oe, out_we};
    endfunction

    task automatic model_reset();
        m_step = 0; m_halted = 0; m_count = 0;
        h0 = 0; h1 = 0; h2 = 0;
    endtask

    // Entered just after a rising edge; checks mid-cycle, then steps the model.
    task automatic tick();
        logic [11:0] exp;
        bit pulse, adv;
        #1;
        pulse = h1 & ~h2;
        adv = !m_halted && (run || pulse);
        exp = ref_word(m_step, opcode);
        exp = (exp & BUS_MASK) | (adv ? (exp & WR_MASK) : 12'h0);
        chk("t_state", {26'b0, t_state}, 32'(1 << m_step));
        chk("ctrl", {20'b0, obs_word()}, {20'b0, exp});
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        chk("instr_count", {24'b0, instr_count}, 32'(m_count));
        chk("bus_excl", 32'($countones({pc_oe, ram_oe, ir_oe, acc_oe, alu_oe}) <= 1), 32'd1);
        @(posedge CLK);
        if (adv) begin
            if (m_step == 3 && opcode == 4'hF) m_halted = 1;
            else begin
                if (m_step == 5) m_count = (m_count + 1) % 256;
                m_step = (m_step + 1) % 6;
            end
        end
        h2 = h1; h1 = h0; h0 = step_in;
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        chk("rst_t_state", {26'b0, t_state}, 32'h1);
        chk("rst_ctrl", {20'b0, obs_word()}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_count", {24'b0, instr_count}, 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    initial begin
        int changes, mar_pulses, hold;
        logic [5:0] prev_t;
        RESET = 1'b1; run = 1'b1; step_in = 1'b0; opcode = 4'h0;
        model_reset();
        @(posedge CLK);
        #1;
        do_reset();

        // LDA free-run: one full instruction
        opcode = 4'h0; run = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("lda_count", {24'b0, instr_count}, 32'd1);

        // SUB free-run
        opcode = 4'h2;
        for (int i = 0; i < 6; i++) tick();
        chk("sub_count", {24'b0, instr_count}, 32'd2);

        // Single-step: button held for 100 cycles gives exactly one advance
        do_reset();
        run = 1'b0; opcode = 4'h1;
        changes = 0; mar_pulses = 0;
        step_in = 1'b1;
        for (int i = 0; i < 110; i++) begin
            if (i == 100) step_in = 1'b0;
            prev_t = t_state;
            #1;
            if (mar_we) mar_pulses++;
            #0;
            tick();
            if (t_state !== prev_t) changes++;
        end
        chk("step_changes", 32'(changes), 32'd1);
        chk("step_mar_pulses", 32'(mar_pulses), 32'd1);
        chk("step_t_state", {26'b0, t_state}, 32'h2);

        // Random run/step/opcode activity, HLT excluded
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) run = 1'($urandom);
            if (hold == 0) begin
                step_in = 1'($urandom);
                hold = $urandom_range(1, 4);
            end
            hold--;
            opcode = 4'($urandom_range(0, 14));
            tick();
        end

        // Asynchronous reset in T5 of ADD
        do_reset();
        opcode = 4'h1; run = 1'b1; step_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_t5", {26'b0, t_state}, 32'h10);
        RESET = 1'b1;
        #1;
        chk("async_t_state", {26'b0, t_state}, 32'h1);
        chk("async_ctrl", {20'b0, obs_word()}, 32'h0);
        chk("async_halted", {31'b0, halted}, 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) tick();

        // HLT: sticky, immune to run and step activity
        do_reset();
        opcode = 4'hF; run = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        for (int i = 0; i < 40; i++) begin
            run = 1'($urandom);
            step_in = 1'(i / 3);
            tick();
        end
        chk("hlt_halted", {31'b0, halted}, 32'd1);
        chk("hlt_t_state", {26'b0, t_state}, 32'h8);
        chk("hlt_count", {24'b0, instr_count}, 32'd0);

        // 256 NOPs: counter wraps
        do_reset();
        opcode = 4'h3; run = 1'b1; step_in = 1'b0;
        for (int i = 0; i < 255 * 6; i++) tick();
        chk("nop_255", {24'b0, instr_count}, 32'd255);
        for (int i = 0; i < 6; i++) tick();
        chk("nop_wrap", {24'b0, instr_count}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
